// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared constants and the buffered-entry type for the ID/EX stage.
//   - RV64 opcode constants handled by the stage
//   - 4-bit ALU control codes
//   - id_ex_entry_t: one skid-buffer slot
//   - id_ex_fwd(): applies a writeback forward to a stored/incoming entry
// Optional feature macro: ID_EX_FWD_EN (adds source indices to each entry and
// enables writeback forwarding into buffered operands).
package id_ex_pkg;

   localparam int ID_EX_XLEN  = 64;
   localparam int ID_EX_REG_W = 5;

   localparam logic [6:0] OPC_R     = 7'b0110011;
   localparam logic [6:0] OPC_IALU  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_OR  = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0111;

   typedef struct packed {
      logic [ID_EX_XLEN-1:0]  a;
      logic [ID_EX_XLEN-1:0]  b;
      logic [3:0]             ctrl;
      logic [ID_EX_REG_W-1:0] rd;
      logic                   reg_write;
      logic                   illegal;
`ifdef ID_EX_FWD_EN
      logic [ID_EX_REG_W-1:0] rs1;
      logic [ID_EX_REG_W-1:0] rs2;
      logic                   use_rs2;
`endif
   } id_ex_entry_t;

`ifdef ID_EX_FWD_EN
   // x0 is never forwarded; b is only a register operand for R-type entries.
   function automatic id_ex_entry_t id_ex_fwd(input id_ex_entry_t e,
                                              input logic wb_valid,
                                              input logic [ID_EX_REG_W-1:0] wb_rd,
                                              input logic [ID_EX_XLEN-1:0] wb_data);
      id_ex_entry_t r;
      r = e;
      if (wb_valid && (wb_rd != '0)) begin
         if (e.rs1 == wb_rd) r.a = wb_data;
         if (e.use_rs2 && (e.rs2 == wb_rd)) r.b = wb_data;
      end
      return r;
   endfunction
`endif

endpackage

// File: rtl/id_ex_if.sv
// id_ex_if: bundles the ID-side input channel, the EX-side output channel,
// flush and the writeback snoop port of the ID/EX stage.
//   master: environment (ID stage + EX/ALU + writeback) view
//   slave : id_ex_stage view
interface id_ex_if #(
   parameter int XLEN       = 64,
   parameter int REG_ADDR_W = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic                  funct7_5;
   logic [REG_ADDR_W-1:0] rs1_addr;
   logic [REG_ADDR_W-1:0] rs2_addr;
   logic [XLEN-1:0]       rs1_data;
   logic [XLEN-1:0]       rs2_data;
   logic [XLEN-1:0]       imm;
   logic [REG_ADDR_W-1:0] rd_in;
   logic                  flush;
   logic                  wb_valid;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic [XLEN-1:0]       wb_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [XLEN-1:0]       a;
   logic [XLEN-1:0]       b;
   logic [3:0]            alu_control_signal;
   logic [REG_ADDR_W-1:0] rd_out;
   logic                  reg_write;
   logic                  illegal;

   modport master (
      output in_valid, opcode, funct3, funct7_5, rs1_addr, rs2_addr,
             rs1_data, rs2_data, imm, rd_in, flush, wb_valid, wb_rd, wb_data,
             out_ready,
      input  in_ready, out_valid, a, b, alu_control_signal, rd_out,
             reg_write, illegal
   );

   modport slave (
      input  in_valid, opcode, funct3, funct7_5, rs1_addr, rs2_addr,
             rs1_data, rs2_data, imm, rd_in, flush, wb_valid, wb_rd, wb_data,
             out_ready,
      output in_ready, out_valid, a, b, alu_control_signal, rd_out,
             reg_write, illegal
   );
endinterface

// File: rtl/id_ex_decode.sv
// id_ex_decode: combinational opcode/funct translation.
//   i_opcode, i_funct3, i_funct7_5 : instruction fields
//   i_rd                           : destination index (x0 suppresses write)
//   o_ctrl                         : 4-bit ALU control code
//   o_b_sel_rs2                    : 1 = operand b from rs2_data, 0 = imm
//   o_reg_write, o_illegal         : writeback enable, unsupported opcode
module id_ex_decode
   import id_ex_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [6:0]            i_opcode,
   input  logic [2:0]            i_funct3,
   input  logic                  i_funct7_5,
   input  logic [REG_ADDR_W-1:0] i_rd,
   output logic [3:0]            o_ctrl,
   output logic                  o_b_sel_rs2,
   output logic                  o_reg_write,
   output logic                  o_illegal
);

   always_comb begin
      o_ctrl      = ALU_ADD;
      o_b_sel_rs2 = 1'b0;
      o_reg_write = 1'b0;
      o_illegal   = 1'b0;
      case (i_opcode)
         OPC_R: begin
            o_ctrl      = {i_funct7_5, i_funct3};
            o_b_sel_rs2 = 1'b1;
            o_reg_write = 1'b1;
         end
         OPC_IALU: begin
            // bit 30 of an I-type is immediate data except for the shift-right pair
            o_ctrl      = {(i_funct3 == 3'b101) ? i_funct7_5 : 1'b0, i_funct3};
            o_reg_write = 1'b1;
         end
         OPC_LOAD:  o_reg_write = 1'b1;
         OPC_STORE: o_reg_write = 1'b0;
         default:   o_illegal   = 1'b1;
      endcase
      if (i_rd == '0) o_reg_write = 1'b0;
   end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute stage with a two-entry skid buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : id_ex_if.slave (input channel, output channel, flush, wb snoop)
// Head slot drives the outputs; outputs read zero while out_valid is low.
// Optional feature macro: ID_EX_FWD_EN (writeback forwarding into entries).
module id_ex_stage
   import id_ex_pkg::*;
#(
   parameter int XLEN       = ID_EX_XLEN,
   parameter int REG_ADDR_W = ID_EX_REG_W
) (
   input  logic   clk,
   input  logic   rst_n,
   id_ex_if.slave bus
);

   id_ex_entry_t r_head, r_tail;
   logic [1:0]   r_count;

   logic         w_out_valid, w_push, w_pop;
   logic [3:0]   w_ctrl;
   logic         w_b_sel_rs2, w_reg_write, w_illegal;
   id_ex_entry_t w_cap, w_new, w_head, w_tail;

   id_ex_decode #(.REG_ADDR_W(REG_ADDR_W)) u_decode (
      .i_opcode    (bus.opcode),
      .i_funct3    (bus.funct3),
      .i_funct7_5  (bus.funct7_5),
      .i_rd        (bus.rd_in),
      .o_ctrl      (w_ctrl),
      .o_b_sel_rs2 (w_b_sel_rs2),
      .o_reg_write (w_reg_write),
      .o_illegal   (w_illegal)
   );

   assign w_out_valid = (r_count != 2'd0);
   assign bus.in_ready = (r_count != 2'd2);
   // a flushed cycle neither accepts nor consumes anything
   assign w_push = bus.in_valid && bus.in_ready && !bus.flush;
   assign w_pop  = w_out_valid && bus.out_ready && !bus.flush;

   always_comb begin
      w_cap           = '0;
      w_cap.a         = bus.rs1_data;
      w_cap.b         = w_b_sel_rs2 ? bus.rs2_data : bus.imm;
      w_cap.ctrl      = w_ctrl;
      w_cap.rd        = bus.rd_in;
      w_cap.reg_write = w_reg_write;
      w_cap.illegal   = w_illegal;
`ifdef ID_EX_FWD_EN
      w_cap.rs1       = bus.rs1_addr;
      w_cap.rs2       = bus.rs2_addr;
      w_cap.use_rs2   = w_b_sel_rs2;
`endif
   end

`ifdef ID_EX_FWD_EN
   assign w_new  = id_ex_fwd(w_cap,  bus.wb_valid, bus.wb_rd, bus.wb_data);
   assign w_head = id_ex_fwd(r_head, bus.wb_valid, bus.wb_rd, bus.wb_data);
   assign w_tail = id_ex_fwd(r_tail, bus.wb_valid, bus.wb_rd, bus.wb_data);
`else
   logic w_unused_fwd;
   assign w_unused_fwd = ^{bus.rs1_addr, bus.rs2_addr, bus.wb_valid, bus.wb_rd, bus.wb_data};
   assign w_new  = w_cap;
   assign w_head = r_head;
   assign w_tail = r_tail;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 2'd0;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         r_head <= w_head;
         r_tail <= w_tail;
         if (bus.flush) begin
            r_count <= 2'd0;
         end else begin
            case ({w_push, w_pop})
               // only reachable at count 1: new entry replaces the consumed head
               2'b11: r_head <= w_new;
               2'b01: begin
                  r_head  <= w_tail;
                  r_count <= r_count - 2'd1;
               end
               2'b10: begin
                  if (r_count == 2'd0) r_head <= w_new;
                  else                 r_tail <= w_new;
                  r_count <= r_count + 2'd1;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.out_valid          = w_out_valid;
   assign bus.a                  = w_out_valid ? r_head.a    : {XLEN{1'b0}};
   assign bus.b                  = w_out_valid ? r_head.b    : {XLEN{1'b0}};
   assign bus.alu_control_signal = w_out_valid ? r_head.ctrl : 4'b0000;
   assign bus.rd_out             = w_out_valid ? r_head.rd   : {REG_ADDR_W{1'b0}};
   assign bus.reg_write          = w_out_valid && r_head.reg_write;
   assign bus.illegal            = w_out_valid && r_head.illegal;

endmodule
